lvds_pixel_addr_gen: RTL and testbench

//  Raster timing and pixel-address generator for the LVDS panel test path.

---
 rtl/lvds_pixel_addr_gen.sv | 165 ++++++++++++++++
 tb/tb_lvds_pixel_addr_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lvds_pixel_addr_gen.sv
// ============================================================================
//  Module      : lvds_pixel_addr_gen
//  Description : Raster timing and frame-RAM address generator for the LVDS
//                panel test path (read strobe, X/Y address, syncs, DE).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lvds_pixel_addr_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 80,
  parameter int V_ACTIVE = 800,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 14,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] addrX,
  output logic [31:0] addrY,
  output logic        rd,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] c_H_ACTIVE   = 11'(H_ACTIVE);
  localparam logic [10:0] c_V_ACTIVE   = 11'(V_ACTIVE);
  localparam logic [10:0] c_H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] c_V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic        r_busy;

  // Stage 1 (RAM request) and stage 2 (panel side) registers
  logic        r_rd;
  logic [10:0] r_addr_x;
  logic [10:0] r_addr_y;
  logic        r_frame_start;
  logic        r_hs_act1;
  logic        r_vs_act1;
  logic        r_de;
  logic        r_hsync;
  logic        r_vsync;

  logic w_run;
  logic w_h_last;
  logic w_v_last;
  logic w_active;
  logic w_hs_act;
  logic w_vs_act;

  assign w_run    = (r_state == ST_RUN);
  assign w_h_last = (r_h_cnt == c_H_LAST);
  assign w_v_last = (r_v_cnt == c_V_LAST);
  assign w_active = w_run && (r_h_cnt < c_H_ACTIVE) && (r_v_cnt < c_V_ACTIVE);
  assign w_hs_act = w_run && (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
  assign w_vs_act = w_run && (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);

  // Run control: en is only honoured at the frame boundary so frames are never torn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_h_cnt <= 11'd0;
      r_v_cnt <= 11'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_h_cnt <= 11'd0;
          r_v_cnt <= 11'd0;
          if (en) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_h_last) begin
            r_h_cnt <= 11'd0;
            if (w_v_last) begin
              r_v_cnt <= 11'd0;
              if (!en) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_v_cnt <= r_v_cnt + 11'd1;
            end
          end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd          <= 1'b0;
      r_addr_x      <= 11'd0;
      r_addr_y      <= 11'd0;
      r_frame_start <= 1'b0;
      r_hs_act1     <= 1'b0;
      r_vs_act1     <= 1'b0;
    end else begin
      r_rd          <= w_active;
      r_frame_start <= w_run && (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
      r_hs_act1     <= w_hs_act;
      r_vs_act1     <= w_vs_act;
      if (w_active) begin
        r_addr_x <= r_h_cnt;
        r_addr_y <= r_v_cnt;
      end
    end
  end

  // Stage 2 lines up with RAM read data (1-clk read latency).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_de    <= 1'b0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
    end else begin
      r_de    <= r_rd;
      r_hsync <= r_hs_act1 ? SYNC_POL : ~SYNC_POL;
      r_vsync <= r_vs_act1 ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign addrX       = r_addr_x;
  assign addrY       = {21'b0, r_addr_y};
  assign rd          = r_rd;
  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_lvds_pixel_addr_gen.sv
// ============================================================================
//  Module      : tb_lvds_pixel_addr_gen
//  Description : Self-checking bench for lvds_pixel_addr_gen, small raster.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lvds_pixel_addr_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [10:0] addrX;
  logic [31:0] addrY;
  logic        rd, de, hsync, vsync, frame_start, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int last_fs = -1;

  // Model: absolute pixel index since run start (-1 = idle), for the current
  // state and the two previous clocks.
  int          p0 = -1, p1 = -1, p2 = -1;
  logic [10:0] ax_m = '0;
  logic [31:0] ay_m = '0;

  lvds_pixel_addr_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .addrX(addrX), .addrY(addrY), .rd(rd), .de(de),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int hpos(input int p); return p % HT; endfunction
  function automatic int vpos(input int p); return (p / HT) % VT; endfunction

  function automatic logic m_rd(input int p);
    return (p >= 0) && (hpos(p) < HA) && (vpos(p) < VA);
  endfunction
  function automatic logic m_hs(input int p);
    return (p >= 0) && (hpos(p) >= HA + HF) && (hpos(p) < HA + HF + HS);
  endfunction
  function automatic logic m_vs(input int p);
    return (p >= 0) && (vpos(p) >= VA + VF) && (vpos(p) < VA + VF + VS);
  endfunction

  task automatic step();
    logic en_s;
    en_s = en;
    @(posedge clk);
    p2 = p1;
    p1 = p0;
    if (p0 < 0)                 p0 = en_s ? 0 : -1;
    else if (p0 % FT == FT - 1) p0 = en_s ? p0 + 1 : -1;
    else                        p0 = p0 + 1;
    if (m_rd(p1)) begin
      ax_m = 11'(hpos(p1));
      ay_m = 32'(vpos(p1));
    end
    cyc++;
    #1;
    chk("rd", 32'(rd), 32'(m_rd(p1)));
    chk("de", 32'(de), 32'(m_rd(p2)));
    chk("hsync", 32'(hsync), 32'(!m_hs(p2)));
    chk("vsync", 32'(vsync), 32'(!m_vs(p2)));
    chk("frame_start", 32'(frame_start), 32'((p1 >= 0) && (p1 % FT == 0)));
    chk("busy", 32'(busy), 32'(p0 >= 0));
    chk("addrX", 32'(addrX), 32'(ax_m));
    chk("addrY", addrY, ay_m);
    if (rd) rd_cnt++;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_addrX", 32'(addrX), 32'd0);
    chk("rst_addrY", addrY, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    p0 = -1; p1 = -1; p2 = -1;
    ax_m = '0; ay_m = '0;
    #2 rst = 1'b0;
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    while (!frame_start && n < 3 * FT) begin
      step();
      n++;
    end
    chk(tag, 32'(frame_start), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    #12 rst = 1'b0;

    // Reset/idle state
    repeat (3) step();

    // Start, then async reset mid-frame and restart
    en = 1'b1;
    repeat (30) step();
    async_reset();
    repeat (20) step();

    // Frame period over several back-to-back frames
    wait_fs("fs_found");
    last_fs = cyc;
    for (int f = 0; f < 3; f++) begin
      step();
      wait_fs("fs_next");
      chk("fs_period", 32'(cyc - last_fs), 32'(FT));
      last_fs = cyc;
    end

    // en dropped mid-frame: frame must complete then stop
    rd_cnt = 1;
    repeat (HT + 3) step();
    en = 1'b0;
    begin
      int n;
      n = 0;
      while (busy && n < 2 * FT) begin
        step();
        n++;
      end
    end
    chk("stop_busy", 32'(busy), 32'd0);
    chk("rd_per_frame", 32'(rd_cnt), 32'(HA * VA));
    repeat (10) step();
    chk("rd_after_stop", 32'(rd_cnt), 32'(HA * VA));

    // Randomised en toggling with occasional async resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 4) en = ~en;
      if ($urandom_range(0, 999) < 3) async_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
